// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with a one-word holding register so that
// consecutive words can stream out with no idle cycle between them.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             msb_first,
  input  logic             pause,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full_reg;
  logic [WIDTH-1:0] sr_reg;
  logic             order_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH-1:0] sr_toward_msb;
  logic [WIDTH-1:0] sr_toward_lsb;
  logic [WIDTH-1:0] sr_next;
  logic             shifting;
  logic             last_bit;
  logic             accept;
  logic             start;

  // Both shift directions are built explicitly; the latched order picks one.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_msb_lo
        assign sr_toward_msb[gi] = 1'b0;
      end else begin : g_msb_hi
        assign sr_toward_msb[gi] = sr_reg[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_lsb_hi
        assign sr_toward_lsb[gi] = 1'b0;
      end else begin : g_lsb_lo
        assign sr_toward_lsb[gi] = sr_reg[gi+1];
      end
    end
  endgenerate

  assign sr_next    = order_reg ? sr_toward_msb : sr_toward_lsb;
  assign shifting   = (state_reg == SHIFT) && !pause;
  assign last_bit   = shifting && (cnt_reg == LAST);
  assign accept     = load_valid && !hold_full_reg;
  // A held word moves into the shifter from IDLE or on the final bit edge.
  assign start      = hold_full_reg && ((state_reg == IDLE) || last_bit);

  assign load_ready = !hold_full_reg;
  assign sout_valid = shifting;
  assign sout       = shifting && (order_reg ? sr_reg[WIDTH-1] : sr_reg[0]);
  assign frame_done = last_bit;
  assign busy       = (state_reg == SHIFT) || hold_full_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      sr_reg        <= '0;
      order_reg     <= 1'b1;
      cnt_reg       <= '0;
    end else begin
      if (start) begin
        sr_reg    <= hold_reg;
        order_reg <= msb_first;
        cnt_reg   <= '0;
        state_reg <= SHIFT;
      end else if (last_bit) begin
        sr_reg    <= sr_next;
        cnt_reg   <= '0;
        state_reg <= IDLE;
      end else if (shifting) begin
        sr_reg  <= sr_next;
        cnt_reg <= cnt_reg + CW'(1);
      end

      // accept needs an empty holder and start needs a full one, so they never coincide.
      if (accept) begin
        hold_reg      <= din;
        hold_full_reg <= 1'b1;
      end else if (start) begin
        hold_full_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed frames with literal expectations plus a
// randomized run compared every cycle against a queue-based bit-stream model.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         msb_first = 1'b1;
  logic         pause = 1'b0;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         frame_done;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] seq;
  logic [15:0] fd;
  logic [31:0] vpat;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .msb_first  (msb_first),
    .pause      (pause),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the bits still to be sent for the current word, plus an optional held word.
  bit           cur_q[$];
  bit           held = 1'b0;
  logic [W-1:0] hold_w = '0;
  bit           m_acc;
  bit           m_order;
  bit           m_pause;
  logic [W-1:0] m_din;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q.delete();
      held = 1'b0;
    end else begin
      m_acc   = load_valid && !held;
      m_din   = din;
      m_order = msb_first;
      m_pause = pause;
      if (cur_q.size() > 0 && !m_pause) void'(cur_q.pop_front());
      if (cur_q.size() == 0 && held) begin
        for (int i = 0; i < W; i++) cur_q.push_back(m_order ? hold_w[W-1-i] : hold_w[i]);
        held = 1'b0;
      end
      if (m_acc) begin
        held   = 1'b1;
        hold_w = m_din;
      end
    end
  end

  bit c_act;
  bit c_val;

  always @(negedge clk) begin
    c_act = cur_q.size() > 0;
    c_val = c_act && !pause;
    check("sout_valid", sout_valid, c_val);
    check("sout", sout, c_val ? cur_q[0] : 1'b0);
    check("frame_done", frame_done, c_val && cur_q.size() == 1);
    check("load_ready", load_ready, !held);
    check("busy", busy, c_act || held);
  end

  task automatic send_word(input logic [W-1:0] w, input bit m);
    din = w;
    msb_first = m;
    load_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (load_ready) begin
        @(posedge clk);
        #1 load_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: word %0h never accepted", w);
    load_valid = 1'b0;
  endtask

  // Collect n valid bits; vpat logs sout_valid from the first valid cycle on.
  task automatic capture(input int n, output logic [15:0] s, output logic [15:0] f,
                         output logic [31:0] vp);
    int got = 0;
    int cyc = 0;
    s = '0;
    f = '0;
    vp = '0;
    while (got < n && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (got > 0 || sout_valid) vp = {vp[30:0], sout_valid};
      if (sout_valid) begin
        s = {s[14:0], sout};
        f = {f[14:0], frame_done};
        got++;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: got %0d bits, required %0d", got, n);
    end
  endtask

  // Called just after a rising edge with the block idle.
  task automatic directed_single(input string name, input logic [W-1:0] w, input bit m,
                                 input logic [7:0] seq_exp);
    din = w;
    msb_first = m;
    load_valid = 1'b1;
    @(negedge clk);
    check({name, "_ready"}, load_ready, 1);
    @(posedge clk);
    #1 load_valid = 1'b0;
    @(negedge clk);
    check({name, "_held_ready"}, load_ready, 0);
    check({name, "_held_valid"}, sout_valid, 0);
    check({name, "_held_busy"}, busy, 1);
    @(posedge clk);
    #1 msb_first = !m;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("%s_valid%0d", name, i), sout_valid, 1);
      check($sformatf("%s_bit%0d", name, i), sout, seq_exp[7-i]);
      check($sformatf("%s_fd%0d", name, i), frame_done, (i == 7));
    end
    @(negedge clk);
    check({name, "_end_valid"}, sout_valid, 0);
    check({name, "_end_busy"}, busy, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_sout", sout, 0);
      check("rst_valid", sout_valid, 0);
      check("rst_ready", load_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_fd", frame_done, 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    directed_single("a5_msb", 8'hA5, 1'b1, 8'b10100101);
    @(posedge clk); #1;
    directed_single("0d_lsb", 8'h0D, 1'b0, 8'b10110000);
    @(posedge clk); #1;

    fork
      begin send_word(8'hA5, 1'b1); send_word(8'h5A, 1'b1); end
      capture(16, seq, fd, vpat);
    join
    check("b2b_bits", seq, 16'hA55A);
    check("b2b_fd", fd, 16'h0101);
    check("b2b_gapless", vpat, 32'h0000FFFF);
    repeat (3) @(posedge clk);
    #1;

    fork
      begin
        send_word(8'hA5, 1'b1);
        repeat (4) @(posedge clk);
        #1 pause = 1'b1;
        repeat (3) @(posedge clk);
        #1 pause = 1'b0;
      end
      capture(8, seq, fd, vpat);
    join
    check("pause_bits", seq, 16'h00A5);
    check("pause_fd", fd, 16'h0001);
    check("pause_vpat", vpat, 32'h0000071F);
    repeat (3) @(posedge clk);
    #1;

    fork
      begin send_word(8'hA5, 1'b1); send_word(8'h3C, 1'b1); end
      begin
        int nb = 0;
        for (int i = 0; i < 40 && nb < 4; i++) begin
          @(negedge clk);
          if (sout_valid) nb++;
        end
        if (nb < 4) begin
          checks++;
          errors++;
          $display("FAIL rst_mid_timeout: saw %0d bits, required 4", nb);
        end
        check("rst_mid_pre_ready", load_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", sout_valid, 0);
        check("rst_mid_sout", sout, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", load_ready, 1);
        check("rst_mid_fd", frame_done, 0);
      end
    join
    @(posedge clk);
    #1 rst = 1'b0;
    directed_single("f0_after_rst", 8'hF0, 1'b1, 8'b11110000);
    @(posedge clk); #1;

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst        = ($urandom_range(0, 249) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      din        = W'($urandom);
      msb_first  = 1'($urandom_range(0, 1));
      pause      = ($urandom_range(0, 4) == 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_valid = 1'b0;
    pause = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-005 The block SHALL have port load_valid, input, 1 bit: din is valid this cycle.
REQ-006 The block SHALL have port load_ready, output, 1 bit: the holding register can accept a word this cycle.
REQ-007 The block SHALL have port msb_first, input, 1 bit: bit order (1 = MSB first, 0 = LSB first).
REQ-008 The block SHALL have port pause, input, 1 bit: stall serial output this cycle.
REQ-009 The block SHALL have port sout, output, 1 bit: serial data bit that feeds the downstream sequence detector's x input.
REQ-010 The block SHALL have port sout_valid, output, 1 bit: sout carries a data bit this cycle.
REQ-011 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse marking the last bit of a word.
REQ-012 The block SHALL have port busy, output, 1 bit: FSM is in SHIFT or the holding register is full.

Function
REQ-013 The block SHALL contain a WIDTH-bit holding register with full flag hold_full, a WIDTH-bit shift register sr, a latched order bit, and a bit counter cnt (0..WIDTH-1).
REQ-014 load_ready SHALL equal !hold_full (combinational); a word SHALL be accepted on an edge where load_valid && load_ready, setting hold_full.
REQ-015 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-016 In IDLE with hold_full=1, the next edge SHALL copy hold to sr, latch msb_first, clear cnt, clear hold_full, and enter SHIFT.
REQ-017 In SHIFT with pause=0, sout_valid SHALL be 1 and sout SHALL be sr[WIDTH-1] (order=1) or sr[0] (order=0); each edge SHALL shift sr toward the output end and increment cnt.
REQ-018 In SHIFT with pause=1, sout_valid SHALL be 0, sout SHALL be 0, and sr/cnt SHALL hold.
REQ-019 In IDLE, sout and sout_valid SHALL be 0.
REQ-020 frame_done SHALL be 1 exactly when state=SHIFT, cnt=WIDTH-1 and pause=0.
REQ-021 On the last-bit edge (frame_done=1), if hold_full=1 the block SHALL reload sr from hold, relatch msb_first, clear cnt, clear hold_full and stay in SHIFT with no idle cycle; otherwise it SHALL enter IDLE.
REQ-022 Latency: a word accepted on edge N SHALL present its first bit, with sout_valid=1, in the cycle after edge N+1 (absent pause).
REQ-023 msb_first changes while shifting SHALL NOT affect the word in progress.
REQ-024 Back-to-back words SHALL stream gaplessly when load_valid is held high, since hold drains at least WIDTH-1 cycles before the last bit.

Reset
REQ-025 While rst=1 the block SHALL asynchronously force state=IDLE, hold_full=0, sr=0, cnt=0, order=1, giving sout=0, sout_valid=0, frame_done=0, busy=0, load_ready=1.
REQ-026 Reset mid-word SHALL discard both the word being shifted and any held word; after release, the first accepted word SHALL serialize from bit 0 of its sequence.

Verification
REQ-027 The bench SHALL cover: rst=1 for 2 cycles -> sout=0, sout_valid=0, load_ready=1, busy=0.
REQ-028 The bench SHALL cover: WIDTH=8, din=8'hA5, msb_first=1, accepted at edge N -> sout=1,0,1,0,0,1,0,1 in the 8 cycles after edge N+1, frame_done high only in the 8th.
REQ-029 The bench SHALL cover: din=8'h0D, msb_first=0 -> sout=1,0,1,1,0,0,0,0.
REQ-030 The bench SHALL cover: 8'hA5 then 8'h5A offered back-to-back (MSB first) -> 16 consecutive sout_valid cycles carrying 10100101 01011010, with frame_done pulsing twice.
REQ-031 The bench SHALL cover: pause=1 for 3 cycles after the 3rd bit of 8'hA5 -> sout_valid=0 for those 3 cycles, then bits resume 0,0,1,0,1 unchanged.
REQ-032 The bench SHALL cover: rst pulsed after the 4th bit with 8'h3C held -> outputs cleared at once, held word lost; a subsequent 8'hF0 serializes 1,1,1,1,0,0,0,0.
